// File: rtl/vc_pkg.sv
// Shared types and constants for the victim-cache control path.
package vc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SWAP,
        L2_READ,
        WB,
        INSERT
    } vc_ctrl_state_t;

    localparam logic L2_ADDR_REQ = 1'b0;
    localparam logic L2_ADDR_VC  = 1'b1;

endpackage

// File: rtl/vc_control_if.sv
// L1-side and L2-side handshake bundle of the victim-cache controller.
// Handshake: l1_req is sampled only while vc_busy is low; l1_resp is a
// one-cycle pulse. l2_read/l2_write are held high up to and including the
// cycle in which l2_resp pulses, and the transfer completes in that cycle.
interface vc_control_if;
    logic l1_req;
    logic l1_victim_valid;
    logic l1_victim_dirty;
    logic l1_resp;
    logic l1_resp_from_vc;
    logic vc_busy;
    logic l2_read;
    logic l2_write;
    logic l2_resp;
    logic l2_addr_sel;

    modport master (
        input  l1_req, l1_victim_valid, l1_victim_dirty, l2_resp,
        output l1_resp, l1_resp_from_vc, vc_busy, l2_read, l2_write, l2_addr_sel
    );

    modport slave (
        output l1_req, l1_victim_valid, l1_victim_dirty, l2_resp,
        input  l1_resp, l1_resp_from_vc, vc_busy, l2_read, l2_write, l2_addr_sel
    );
endinterface

// File: rtl/vc_idx_encoder.sv
// Lowest-set-bit priority encoder with a found flag.
module vc_idx_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_control.sv
// Victim-cache control FSM: probes on an L1 miss, swaps on a hit, otherwise
// fetches from L2 and inserts the L1 victim, writing back a dirty entry first.
module vc_control
    import vc_pkg::*;
#(
    parameter int vc_size      = 8,
    parameter int num_idx_bits = $clog2(vc_size)
) (
    input  logic                    clk,
    input  logic                    rst,
    vc_control_if.master            bus,
    input  logic [vc_size-1:0]      vc_hit,
    input  logic [vc_size-1:0]      vc_valid_dataout,
    input  logic [vc_size-1:0]      vc_dirty_dataout,
    input  logic [num_idx_bits-1:0] vc_plru_dataout,
    output logic                    vc_valid_read,
    output logic                    vc_dirty_read,
    output logic                    vc_plru_read,
    output logic [vc_size-1:0]      vc_valid_ld,
    output logic [vc_size-1:0]      vc_dirty_ld,
    output logic                    vc_valid_datain,
    output logic                    vc_dirty_datain,
    output logic                    vc_plru_ld,
    output logic [num_idx_bits-1:0] vc_plru_datain,
    output logic [vc_size-1:0]      vc_tag_ld,
    output logic [vc_size-1:0]      vc_data_ld,
    output logic [num_idx_bits-1:0] vc_out_sel,
    output vc_ctrl_state_t          state_dbg
);

    localparam logic [vc_size-1:0] ONE = vc_size'(1);
    localparam logic [num_idx_bits-1:0] IDX_ONE = num_idx_bits'(1);

    vc_ctrl_state_t state_q, state_d;
    logic [num_idx_bits-1:0] hit_idx_q, repl_idx_q;
    logic vic_valid_q, vic_dirty_q;

    logic [num_idx_bits-1:0] hit_idx, inv_idx;
    logic hit_found, inv_found;

    vc_idx_encoder #(.N(vc_size), .W(num_idx_bits)) u_hit_enc (
        .vec_i   (vc_hit & vc_valid_dataout),
        .idx_o   (hit_idx),
        .found_o (hit_found)
    );

    vc_idx_encoder #(.N(vc_size), .W(num_idx_bits)) u_inv_enc (
        .vec_i   (~vc_valid_dataout),
        .idx_o   (inv_idx),
        .found_o (inv_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hit_idx_q   <= '0;
            repl_idx_q  <= '0;
            vic_valid_q <= 1'b0;
            vic_dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == CHECK) begin
                hit_idx_q   <= hit_idx;
                repl_idx_q  <= inv_found ? inv_idx : vc_plru_dataout;
                vic_valid_q <= bus.l1_victim_valid;
                vic_dirty_q <= bus.l1_victim_dirty;
            end
        end
    end

    logic l1_resp, from_vc, l2_read, l2_write, addr_sel, rd_en;
    logic valid_din, dirty_din, plru_ld;
    logic [vc_size-1:0] valid_ld, dirty_ld, tag_ld, data_ld;
    logic [num_idx_bits-1:0] out_sel, plru_din;

    always_comb begin
        state_d   = state_q;
        l1_resp   = 1'b0;
        from_vc   = 1'b0;
        l2_read   = 1'b0;
        l2_write  = 1'b0;
        addr_sel  = L2_ADDR_REQ;
        rd_en     = 1'b1;
        valid_din = 1'b0;
        dirty_din = 1'b0;
        plru_ld   = 1'b0;
        plru_din  = '0;
        valid_ld  = '0;
        dirty_ld  = '0;
        tag_ld    = '0;
        data_ld   = '0;
        out_sel   = '0;
        case (state_q)
            IDLE:   if (bus.l1_req) state_d = CHECK;
            CHECK:  state_d = hit_found ? SWAP : L2_READ;
            SWAP: begin
                out_sel  = hit_idx_q;
                l1_resp  = 1'b1;
                from_vc  = 1'b1;
                valid_ld = ONE << hit_idx_q;
                dirty_ld = ONE << hit_idx_q;
                if (vic_valid_q) begin
                    tag_ld    = ONE << hit_idx_q;
                    data_ld   = ONE << hit_idx_q;
                    valid_din = 1'b1;
                    dirty_din = vic_dirty_q;
                end
                plru_ld  = 1'b1;
                plru_din = hit_idx_q + IDX_ONE;
                state_d  = IDLE;
            end
            L2_READ: begin
                l2_read = 1'b1;
                if (bus.l2_resp) begin
                    l1_resp = 1'b1;
                    if (!vic_valid_q)
                        state_d = IDLE;
                    else if (vc_valid_dataout[repl_idx_q] && vc_dirty_dataout[repl_idx_q])
                        state_d = WB;
                    else
                        state_d = INSERT;
                end
            end
            WB: begin
                l2_write = 1'b1;
                addr_sel = L2_ADDR_VC;
                out_sel  = repl_idx_q;
                if (bus.l2_resp) state_d = INSERT;
            end
            INSERT: begin
                valid_ld  = ONE << repl_idx_q;
                dirty_ld  = ONE << repl_idx_q;
                tag_ld    = ONE << repl_idx_q;
                data_ld   = ONE << repl_idx_q;
                valid_din = 1'b1;
                dirty_din = vic_dirty_q;
                // Advance the pointer only when the entry it names was consumed.
                if (repl_idx_q == vc_plru_dataout) begin
                    plru_ld  = 1'b1;
                    plru_din = vc_plru_dataout + IDX_ONE;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            l1_resp = 1'b0; from_vc = 1'b0; l2_read = 1'b0; l2_write = 1'b0;
            addr_sel = 1'b0; rd_en = 1'b0; valid_din = 1'b0; dirty_din = 1'b0;
            plru_ld = 1'b0; plru_din = '0; valid_ld = '0; dirty_ld = '0;
            tag_ld = '0; data_ld = '0; out_sel = '0;
        end
    end

    assign bus.l1_resp         = l1_resp;
    assign bus.l1_resp_from_vc = from_vc;
    assign bus.vc_busy         = !rst && (state_q != IDLE);
    assign bus.l2_read         = l2_read;
    assign bus.l2_write        = l2_write;
    assign bus.l2_addr_sel     = addr_sel;
    assign vc_valid_read       = rd_en;
    assign vc_dirty_read       = rd_en;
    assign vc_plru_read        = rd_en;
    assign vc_valid_ld         = valid_ld;
    assign vc_dirty_ld         = dirty_ld;
    assign vc_valid_datain     = valid_din;
    assign vc_dirty_datain     = dirty_din;
    assign vc_plru_ld          = plru_ld;
    assign vc_plru_datain      = plru_din;
    assign vc_tag_ld           = tag_ld;
    assign vc_data_ld          = data_ld;
    assign vc_out_sel          = out_sel;
    assign state_dbg           = state_q;

endmodule

// File: tb/tb_vc_control.sv
// Scoreboard bench for vc_control: directed vectors push expected output
// events; a negedge monitor pops and compares each event the DUT produces.
module tb_vc_control;
    import vc_pkg::*;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int RW = 46;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vc_control_if bus();

    logic [N-1:0]  vc_hit, vc_valid_dataout, vc_dirty_dataout;
    logic [IW-1:0] vc_plru_dataout;
    logic          vc_valid_read, vc_dirty_read, vc_plru_read;
    logic [N-1:0]  vc_valid_ld, vc_dirty_ld, vc_tag_ld, vc_data_ld;
    logic          vc_valid_datain, vc_dirty_datain, vc_plru_ld;
    logic [IW-1:0] vc_plru_datain, vc_out_sel;
    vc_ctrl_state_t state_dbg;

    vc_control #(.vc_size(N), .num_idx_bits(IW)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .vc_hit           (vc_hit),
        .vc_valid_dataout (vc_valid_dataout),
        .vc_dirty_dataout (vc_dirty_dataout),
        .vc_plru_dataout  (vc_plru_dataout),
        .vc_valid_read    (vc_valid_read),
        .vc_dirty_read    (vc_dirty_read),
        .vc_plru_read     (vc_plru_read),
        .vc_valid_ld      (vc_valid_ld),
        .vc_dirty_ld      (vc_dirty_ld),
        .vc_valid_datain  (vc_valid_datain),
        .vc_dirty_datain  (vc_dirty_datain),
        .vc_plru_ld       (vc_plru_ld),
        .vc_plru_datain   (vc_plru_datain),
        .vc_tag_ld        (vc_tag_ld),
        .vc_data_ld       (vc_data_ld),
        .vc_out_sel       (vc_out_sel),
        .state_dbg        (state_dbg)
    );

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_e;
    int n_checks = 0;
    int n_fail   = 0;

    wire [RW-1:0] obs = {bus.l1_resp, bus.l1_resp_from_vc, vc_out_sel,
                         bus.l2_read, bus.l2_write, bus.l2_addr_sel,
                         vc_valid_ld, vc_dirty_ld, vc_valid_datain, vc_dirty_datain,
                         vc_tag_ld, vc_data_ld, vc_plru_ld, vc_plru_datain};
    wire obs_evt = bus.l1_resp | (|vc_valid_ld) | (|vc_dirty_ld) | (|vc_tag_ld) |
                   (|vc_data_ld) | vc_plru_ld | (bus.l2_write & bus.l2_resp);
    wire [3:0] misc = {vc_valid_read, vc_dirty_read, vc_plru_read, bus.vc_busy};

    function automatic logic [RW-1:0] mk(
        input logic resp, input logic from_vc, input logic [IW-1:0] sel,
        input logic rd, input logic wr, input logic asel,
        input logic [N-1:0] vld, input logic [N-1:0] dld, input logic vdi, input logic ddi,
        input logic [N-1:0] tld, input logic [N-1:0] datld,
        input logic pld, input logic [IW-1:0] pdi);
        return {resp, from_vc, sel, rd, wr, asel, vld, dld, vdi, ddi, tld, datld, pld, pdi};
    endfunction

    // Monitor: every output event must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && obs_evt) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event got=%h required=none", obs);
            end else begin
                exp_e = exp_q.pop_front();
                if (obs !== exp_e) begin
                    n_fail++;
                    $display("FAIL scoreboard got=%h required=%h", obs, exp_e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_meta(input logic [N-1:0] v, input logic [N-1:0] d,
                            input logic [IW-1:0] p, input logic [N-1:0] h);
        vc_valid_dataout = v;
        vc_dirty_dataout = d;
        vc_plru_dataout  = p;
        vc_hit           = h;
    endtask

    task automatic do_req(input logic vv, input logic vd);
        bus.l1_req          = 1'b1;
        bus.l1_victim_valid = vv;
        bus.l1_victim_dirty = vd;
        tick();
        bus.l1_req = 1'b0;
    endtask

    task automatic l2_respond(input bit wr, input int delay);
        int k = 0;
        while (!(wr ? bus.l2_write : bus.l2_read) && k < 20) begin
            tick();
            k++;
        end
        chk(wr ? "l2_write_seen" : "l2_read_seen", 64'(k < 20), 64'd1);
        if (k < 20) begin
            repeat (delay) tick();
            bus.l2_resp = 1'b1;
            tick();
            bus.l2_resp = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.vc_busy && k < 20) begin
            tick();
            k++;
        end
        chk("idle_reached", 64'(k < 20), 64'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.l1_req = 1'b0; bus.l1_victim_valid = 1'b0; bus.l1_victim_dirty = 1'b0;
        bus.l2_resp = 1'b0;
        set_meta(8'h00, 8'h00, 3'd0, 8'h00);

        // Reset: everything low, including read enables.
        repeat (2) @(negedge clk);
        chk("reset_outputs", {14'd0, obs, misc}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_misc", 64'(misc), 64'b1110);
        chk("post_reset_state", 64'(state_dbg), 64'(IDLE));

        // Empty VC, miss, dirty victim -> insert at entry 0, pointer 0 -> 1.
        set_meta(8'h00, 8'h00, 3'd0, 8'h00);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 8'h01, 1, 1, 8'h01, 8'h01, 1, 3'd1));
        do_req(1, 1);
        l2_respond(0, 2);
        wait_idle();

        // Hit on entry 3, clean victim -> swap, pointer 4; response two edges after request.
        set_meta(8'h08, 8'h00, 3'd0, 8'h08);
        exp_q.push_back(mk(1, 1, 3, 0, 0, 0, 8'h08, 8'h08, 1, 0, 8'h08, 8'h08, 1, 3'd4));
        do_req(1, 0);
        @(negedge clk);
        chk("hit_no_resp_in_check", 64'(bus.l1_resp), 64'd0);
        @(negedge clk);
        chk("hit_resp_in_swap", 64'(bus.l1_resp), 64'd1);
        wait_idle();

        // Full VC, pointer 7 dirty -> writeback of 7, insert at 7, pointer wraps to 0.
        set_meta(8'hFF, 8'h80, 3'd7, 8'h00);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h80, 8'h80, 1, 0, 8'h80, 8'h80, 1, 3'd0));
        do_req(1, 0);
        l2_respond(0, 1);
        l2_respond(1, 1);
        wait_idle();

        // Entry 4 is the lowest invalid and differs from the pointer -> no pointer load.
        set_meta(8'hEF, 8'h00, 3'd2, 8'h00);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h10, 8'h10, 1, 1, 8'h10, 8'h10, 0, 3'd0));
        do_req(1, 1);
        l2_respond(0, 0);
        wait_idle();

        // Raw hits on 1 and 3 with entry 1 invalid -> hit on 3.
        set_meta(8'hF9, 8'h00, 3'd0, 8'h0A);
        exp_q.push_back(mk(1, 1, 3, 0, 0, 0, 8'h08, 8'h08, 1, 1, 8'h08, 8'h08, 1, 3'd4));
        do_req(1, 1);
        wait_idle();

        // Hit with no victim -> entry 3 invalidated, no tag/data write.
        set_meta(8'h08, 8'h08, 3'd0, 8'h08);
        exp_q.push_back(mk(1, 1, 3, 0, 0, 0, 8'h08, 8'h08, 0, 0, 8'h00, 8'h00, 1, 3'd4));
        do_req(0, 0);
        wait_idle();

        // Miss, no victim, immediate L2 response -> back to IDLE, no loads.
        set_meta(8'h00, 8'h00, 3'd0, 8'h00);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        do_req(0, 0);
        l2_respond(0, 0);
        chk("novic_idle_next", 64'(state_dbg), 64'(IDLE));
        wait_idle();

        // Reset during WB abandons the transaction.
        set_meta(8'hFF, 8'h80, 3'd7, 8'h00);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        do_req(1, 1);
        l2_respond(0, 1);
        chk("in_wb_before_rst", 64'(state_dbg), 64'(WB));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_wb_outputs", {14'd0, obs, misc}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("after_rst_state", 64'(state_dbg), 64'(IDLE));
        chk("after_rst_misc", 64'(misc), 64'b1110);

        set_meta(8'h00, 8'h00, 3'd0, 8'h00);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h01, 8'h01, 1, 0, 8'h01, 8'h01, 1, 3'd1));
        @(posedge clk); #1;
        do_req(1, 0);
        l2_respond(0, 1);
        wait_idle();

        repeat (2) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
